// File: rtl/debounced_input_port_if.sv
// debounced_input_port_if: Wishbone data-bus signals between processor (master) and the input port (slave)
interface debounced_input_port_if;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        stb_i;
  logic        cyc_i;
  logic        ack_o;
  logic        err_o;
  modport master (output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i, input dat_o, ack_o, err_o);
  modport slave  (input adr_i, dat_i, sel_i, we_i, stb_i, cyc_i, output dat_o, ack_o, err_o);
endinterface

// File: rtl/debounced_input_port.sv
// debounced_input_port: synchronised, debounced switch/button port with sticky change events and maskable irq
module debounced_input_port #(
  parameter int WIDTH = 13,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_LEVEL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  debounced_input_port_if.slave bus,
  input  logic [WIDTH-1:0]     i_in,
  output logic                 o_irq
);
  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_ONE  = CNT_WIDTH'(1);
  logic [WIDTH-1:0]     r_sync1, r_sync2, r_state, r_events, r_irq_en;
  logic [CNT_WIDTH-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0]     w_pulse, w_clr, w_wdata;
  logic [31:0]          w_mask, w_rdata, r_dat;
  logic                 w_req, w_wr, r_ack, r_irq, w_unused;
  assign w_req   = bus.cyc_i & bus.stb_i & ~r_ack;
  assign w_wr    = w_req & bus.we_i;
  assign w_mask  = {{8{bus.sel_i[3]}}, {8{bus.sel_i[2]}}, {8{bus.sel_i[1]}}, {8{bus.sel_i[0]}}};
  assign w_wdata = w_mask[WIDTH-1:0] & bus.dat_i[WIDTH-1:0];
  assign w_clr   = (w_wr && bus.adr_i[3:2] == 2'd1) ? w_wdata : '0;
  assign w_rdata = bus.adr_i[3:2] == 2'd0 ? 32'(r_state)  :
                   bus.adr_i[3:2] == 2'd1 ? 32'(r_events) :
                   bus.adr_i[3:2] == 2'd2 ? 32'(r_irq_en) : 32'(r_sync2);
  assign w_unused = ^{bus.adr_i, bus.dat_i, w_mask};
  always_comb begin
    w_pulse = '0;
    for (int k = 0; k < WIDTH; k++)
      w_pulse[k] = (r_sync2[k] != r_state[k]) && (r_cnt[k] == LP_LAST);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= RESET_LEVEL;
      r_sync2  <= RESET_LEVEL;
      r_state  <= RESET_LEVEL;
      r_events <= '0;
      r_irq_en <= '0;
      for (int k = 0; k < WIDTH; k++) r_cnt[k] <= '0;
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_sync1  <= i_in;
      r_sync2  <= r_sync1;
      for (int k = 0; k < WIDTH; k++)
        r_cnt[k] <= (r_sync2[k] == r_state[k] || w_pulse[k]) ? '0 : r_cnt[k] + LP_ONE;
      // a pulse only fires while the bit differs, so toggling lands on sync2
      r_state  <= r_state ^ w_pulse;
      r_events <= (r_events & ~w_clr) | w_pulse;
      r_irq_en <= (w_wr && bus.adr_i[3:2] == 2'd2) ? (r_irq_en & ~w_mask[WIDTH-1:0]) | w_wdata : r_irq_en;
      r_ack    <= w_req;
      r_dat    <= w_req ? w_rdata : '0;
      r_irq    <= |(r_events & r_irq_en);
    end
  end
  assign bus.ack_o = r_ack;
  assign bus.dat_o = r_dat;
  assign bus.err_o = 1'b0;
  assign o_irq     = r_irq;
endmodule

// File: tb/tb_debounced_input_port.sv
// tb_debounced_input_port: directed bench; bus reads queue expected data, a negedge monitor checks every ack
module tb_debounced_input_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] in_bits = '0;
  logic        irq;
  int          checks = 0;
  int          failures = 0;
  string       nq[$];
  logic [31:0] dq[$];
  bit          wq[$];
  debounced_input_port_if bus();
  debounced_input_port #(.WIDTH(13), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16), .RESET_LEVEL(13'h0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .i_in(in_bits), .o_irq(irq));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", n, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    nq.push_back(n); dq.push_back(e); wq.push_back(1'b0);
    bus.adr_i = a; bus.we_i = 1'b0; bus.sel_i = 4'hF; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    tick;
    chk({n, "_ack"}, {31'd0, bus.ack_o}, 32'd1);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    tick;
    chk({n, "_ackdrop"}, {31'd0, bus.ack_o}, 32'd0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    nq.push_back("wr"); dq.push_back('0); wq.push_back(1'b1);
    bus.adr_i = a; bus.dat_i = d; bus.we_i = 1'b1; bus.sel_i = s; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    tick;
    chk("wr_ack", {31'd0, bus.ack_o}, 32'd1);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
  endtask
  always @(negedge clk) begin
    if (bus.ack_o === 1'b1) begin
      chk("err_o", {31'd0, bus.err_o}, 32'd0);
      if (dq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack actual=ack expected=no_ack");
      end else begin
        string n;
        logic [31:0] e;
        bit w;
        n = nq.pop_front(); e = dq.pop_front(); w = wq.pop_front();
        if (!w) chk(n, bus.dat_o, e);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.adr_i = '0; bus.dat_i = '0; bus.sel_i = '0; bus.we_i = 1'b0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    repeat (3) tick;
    chk("rst_ack", {31'd0, bus.ack_o}, 32'd0);
    chk("rst_dat", bus.dat_o, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_err", {31'd0, bus.err_o}, 32'd0);
    rst_n = 1'b1;
    tick;
    rd(32'h0, 32'h0, "state0");
    rd(32'h4, 32'h0, "events0");
    rd(32'h8, 32'h0, "irqen0");
    rd(32'hC, 32'h0, "raw0");
    // button 10 press: state rises on the sixth edge
    in_bits[10] = 1'b1;
    repeat (5) tick;
    chk("state10_e5", {31'd0, dut.r_state[10]}, 32'd0);
    tick;
    chk("state10_e6", {31'd0, dut.r_state[10]}, 32'd1);
    tick;
    chk("irq_masked", {31'd0, irq}, 32'd0);
    rd(32'h0, 32'h400, "state10");
    rd(32'h4, 32'h400, "events10");
    wr(32'h8, 32'h400, 4'hF);
    chk("irq_en_edge", {31'd0, irq}, 32'd0);
    tick;
    chk("irq_on", {31'd0, irq}, 32'd1);
    wr(32'h4, 32'h400, 4'hF);
    chk("irq_clr_edge", {31'd0, irq}, 32'd1);
    tick;
    chk("irq_off", {31'd0, irq}, 32'd0);
    rd(32'h4, 32'h0, "events_clr");
    wr(32'h8, 32'h0000FFFF, 4'b0001);
    tick;
    rd(32'h8, 32'h4FF, "irqen_sel");
    wr(32'h8, 32'hFFFF0000, 4'hF);
    tick;
    rd(32'h8, 32'h0, "irqen_hi");
    wr(32'h0, 32'hFFFF, 4'hF);
    tick;
    rd(32'h0, 32'h400, "state_ro");
    rd(32'h2, 32'h400, "misaligned");
    // three-cycle glitch on bit 3
    in_bits[3] = 1'b1;
    tick;
    tick;
    fork
      rd(32'hC, 32'h408, "raw_glitch");
      begin tick; in_bits[3] = 1'b0; end
    join
    repeat (8) tick;
    rd(32'h0, 32'h400, "state_glitch");
    rd(32'h4, 32'h0, "events_glitch");
    rd(32'hC, 32'h400, "raw_after");
    // clear on the same edge as bit 5's change pulse
    in_bits[5] = 1'b1;
    repeat (5) tick;
    wr(32'h4, 32'h20, 4'hF);
    tick;
    rd(32'h4, 32'h20, "set_wins");
    in_bits[6] = 1'b1;
    repeat (5) tick;
    rd(32'h4, 32'h20, "preset_read");
    rd(32'h4, 32'h60, "set_kept");
    wr(32'h4, 32'h60, 4'hF);
    tick;
    rd(32'h4, 32'h0, "clr_all");
    // reset mid-debounce and mid-bus-cycle
    in_bits = 13'h0001;
    repeat (3) tick;
    bus.adr_i = 32'h0; bus.we_i = 1'b0; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    tick;
    chk("ack_pre_rst", {31'd0, bus.ack_o}, 32'd1);
    chk("cnt0_pre_rst", 32'(dut.r_cnt[0]), 32'd2);
    rst_n = 1'b0;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    #1;
    chk("ack_rst", {31'd0, bus.ack_o}, 32'd0);
    chk("cnt0_rst", 32'(dut.r_cnt[0]), 32'd0);
    repeat (3) tick;
    chk("events_in_rst", 32'(dut.r_events), 32'd0);
    chk("irq_in_rst", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    tick;
    tick;
    chk("sync2_back", {31'd0, dut.r_sync2[0]}, 32'd1);
    repeat (3) tick;
    chk("state0_f5", {31'd0, dut.r_state[0]}, 32'd0);
    tick;
    chk("state0_f6", {31'd0, dut.r_state[0]}, 32'd1);
    rd(32'h8, 32'h0, "irqen_after_rst");
    rd(32'h4, 32'h1, "events_after_rst");
    rd(32'h0, 32'h1, "state_after_rst");
    chk("sb_empty", dq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/debounced_input_port.md
# debounced_input_port

Wishbone slave that brings the board switches and push-buttons into the processor's data-bus address space. It sits directly upstream of the processor interrupt input and beside the LED output register on the data bus. It synchronises and debounces every input bit, latches change events, and drives a maskable level interrupt into the interrupt vector. It is the read-side counterpart of the LED output port and replaces the constant-zero interrupt tie-off.

## Interface
Parameters:
- WIDTH, 13: number of input bits (switches[9:0] at bits 9:0, buttons[2:0] at bits 12:10); range 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a level is accepted; range 1..2^CNT_WIDTH.
- CNT_WIDTH, 16: width of each per-bit stability counter.
- RESET_LEVEL, 0: WIDTH-bit value loaded into the synchroniser and debounced state on reset.

Ports:
- clock  in  1  system bus clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately, deasserting it is synchronous to the design.
- bus  wishboneSlave  —  data-bus slave: adr_i[31:0], dat_i[31:0], dat_o[31:0], sel_i[3:0], we_i, stb_i, cyc_i, ack_o, err_o.
- in  in  WIDTH  raw asynchronous inputs.
- irq  out  1  level interrupt, registered.

## Operation
- Synchroniser: two flops per bit (sync1, sync2), both reset to RESET_LEVEL.
- Debounce, per bit i:
  - While sync2[i] == state[i], cnt[i] is 0.
  - Otherwise cnt[i] increments each cycle.
  - When cnt[i] == DEBOUNCE_CYCLES-1 and the bit still differs, state[i] <= sync2[i], cnt[i] <= 0, and a change pulse is generated.
  - A glitch shorter than DEBOUNCE_CYCLES cycles resets cnt[i] to 0 and leaves state[i] unchanged.
- Registers, decoded on adr_i[3:2]. Only the low 4 bits of the address are decoded; range selection happens upstream.
  - 0x0 STATE, RO: state, zero-extended.
  - 0x4 EVENTS, W1C: sticky change bits. A bit is set by the change pulse and cleared by writing 1. Set wins over a clear in the same cycle.
  - 0x8 IRQ_EN, RW: interrupt mask; reset 0.
  - 0xC RAW, RO: sync2, zero-extended.
- Bits at or above WIDTH read 0 and ignore writes.
- Writes honour sel_i per byte lane. Writes to RO registers are ignored and still acknowledged.
- irq <= |(EVENTS & IRQ_EN), registered. It stays high until software clears the events or the mask.
- err_o is held 0. Misaligned addresses (adr_i[1:0] != 0) are decoded as if aligned.

## Timing
- Reset values:
  - ack_o = 0, dat_o = 0, irq = 0, err_o = 0.
  - EVENTS = 0, IRQ_EN = 0, cnt = 0.
  - state = sync1 = sync2 = RESET_LEVEL, so no spurious event is generated after reset.
- Input latency: a clean change on in[i] before edge 0 appears in sync2 after edge 2. It reaches state[i] and EVENTS[i] after edge 2+DEBOUNCE_CYCLES, and irq one edge later.
- Bus handshake:
  - ack_o <= cyc_i & stb_i & ~ack_o, so the slave answers one cycle after the strobe, holds ack for one cycle and then deasserts it.
  - A held strobe produces ack on alternate cycles.
  - dat_o is registered with ack_o and is 0 when ack_o is low.
  - The write takes effect on the edge that raises ack_o.
- Read data is sampled on the strobe edge. A read of EVENTS in the same cycle as a set returns the pre-set value, and the set is not lost.
- If cyc_i drops mid-transaction, ack_o still completes its single pulse; there is no pending state.
- Reset asserted mid-debounce discards the partial count. Reset asserted mid-bus-cycle forces ack_o low immediately.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, WIDTH=13, RESET_LEVEL=0.

- Reset, then hold in=0 -> STATE=0x0, EVENTS=0x0, irq=0. Each read acks exactly one cycle after the strobe.
- Drive in[10]=1 and hold it -> state[10] rises 6 edges later. EVENTS reads 0x400. irq stays 0 because IRQ_EN=0.
- Write IRQ_EN=0x400 -> irq=1 one edge later. Write EVENTS=0x400 -> EVENTS=0 and irq=0 one edge later.
- Pulse in[3] high for 3 cycles, then return it low -> state[3] stays 0, EVENTS[3]=0, RAW[3] follows the pulse.
- Arrange for a W1C write to EVENTS bit 5 on the same edge that bit 5's change pulse fires -> EVENTS[5] reads 1 afterwards.
- Assert reset while cnt[0]=2 with in[0]=1, then release it with in[0] still 1 -> state[0] updates exactly 4 cycles after sync2 is high again. No event occurs during reset, and IRQ_EN reads 0.
